map_blast_writer: RTL and testbench
===================================

// Module: map_blast_writer
// PURPOSE
//  Write-side owner of tile_map_mem, the counterpart of drawcon's read-only tile lookup.
//  Accepts one bomb placement and writes the bomb tile, then waits out the fuse.
//  Walks the blast rays through its private 1-cycle-latency map read port, writes
//  explosion tiles, holds them, then restores them to empty.
//  drawcon renders the result unchanged.
// PARAMETERS
//  NUM_ROW      11        map rows
//  NUM_COL      19        map columns; addr = row*NUM_COL + col
//  DATA_WIDTH   4         tile code width
//  FUSE_CYCLES  100000000 cycles from bomb write to first blast write
//  HOLD_CYCLES  50000000  cycles explosion tiles stay before clearing
//  BLAST_RANGE  2         max tiles per ray beyond centre (1..7)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  place_valid  in   1   bomb placement request
//  place_row    in   4   bomb row
//  place_col    in   5   bomb column
//  place_ready  out  1   high only in IDLE; handshake = valid & ready
//  place_err    out  1   1-cycle pulse: handshake with row>=NUM_ROW or col>=NUM_COL
//  map_rd_addr  out  8   map read address; data valid next cycle
//  map_rd_data  in   4   tile code from tile_map_mem
//  map_we       out  1   map write enable
//  map_wr_addr  out  8   map write address
//  map_wr_data  out  4   map write data
//  busy         out  1   ~place_ready
//  blast_done   out  1   1-cycle pulse when CLEAR finishes
// BEHAVIOUR
//  Tile codes: 0 empty, 1 hard wall, 2 brick, 3 bomb, 4 explosion.
//  Reset state: IDLE, counters 0, all outputs 0 except place_ready=1.
//  Reset mid-operation: abort to IDLE with no clean-up write; the map is reloaded elsewhere.
//  IDLE: handshake in range -> latch row/col, go ARM.
//    Out-of-range handshake -> place_err pulse, stay IDLE, no write.
//  ARM (1 cyc): map_we=1, wr_data=3 at bomb addr -> FUSE.
//  FUSE: count 0..FUSE_CYCLES-1 -> CENTER.
//  CENTER (1 cyc): write 4 at bomb addr.
//    Then rays in fixed order up, down, left, right; step k=1..BLAST_RANGE.
//  Per step:
//    RD (1 cyc): drive map_rd_addr.
//    EVAL (1 cyc): inspect map_rd_data.
//  EVAL on 0, 3 or 4: write 4, record reach[dir]=k, advance k.
//  EVAL on 1: stop ray, no write.
//  Ray also stops, with no read, when the next step would cross a map edge:
//    row<0, row>=NUM_ROW, col<0 or col>=NUM_COL.
//  Ray also stops when k exceeds BLAST_RANGE.
//  Worst-case scan = 1 + 4*BLAST_RANGE*2 cycles.
//  HOLD: count HOLD_CYCLES -> CLEAR.
//  CLEAR: one write per cycle of 0 to bomb addr, then each ray tile k=1..reach[dir],
//    same direction order; no reads. Then blast_done pulse, -> IDLE.
//  map_we is never high in two different states on the same cycle.
//    wr_addr and wr_data are valid only while map_we=1.
//  Address arithmetic: row*NUM_COL+col in 8 bits; all in-range results < 209.
// CONFIGURATION
//  DESTROY_BRICK_EN defined:
//    EVAL on 2 writes 4, sets reach[dir]=k, then stops the ray.
//    CLEAR turns that tile to 0, so the brick is destroyed.
//  Not defined: tile 2 is treated exactly as 1 (ray stops, no write).
// TESTING
//  Place (5,9), all-empty map, BLAST_RANGE=2, small FUSE/HOLD:
//    writes 3@104, then 4@104,85,66,123,142,103,102,105,106.
//    CLEAR later writes 0 to the same addresses and blast_done pulses once.
//  Place (0,0) on default map -> up/left rays issue no reads; only in-bounds tiles are written.
//  Hard wall at (5,10), bomb (5,9) -> right ray writes nothing; reach[right]=0.
//    CLEAR skips addr 105.
//  Brick at (4,9), bomb (5,9):
//    with DESTROY_BRICK_EN, 85 becomes 4 then 0 and 66 is untouched.
//    Without DESTROY_BRICK_EN, 85 stays 2.
//  place_valid with row=11 -> place_err pulse, no map_we, place_ready stays 1.
//    place_valid while busy -> ignored.
//  rst asserted during FUSE -> next cycle place_ready=1, map_we=0, no blast_done.

Source files
------------

// File: rtl/map_blast_writer.sv
// map_blast_writer: writes a bomb tile into tile_map_mem, waits out the fuse, writes the
// blast rays, holds them, then restores them to empty. Optional feature: DESTROY_BRICK_EN.
module map_blast_writer #(
  parameter int NUM_ROW     = 11,
  parameter int NUM_COL     = 19,
  parameter int DATA_WIDTH  = 4,
  parameter int FUSE_CYCLES = 100000000,
  parameter int HOLD_CYCLES = 50000000,
  parameter int BLAST_RANGE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  place_valid,
  input  logic [3:0]            place_row,
  input  logic [4:0]            place_col,
  output logic                  place_ready,
  output logic                  place_err,
  output logic [7:0]            map_rd_addr,
  input  logic [DATA_WIDTH-1:0] map_rd_data,
  output logic                  map_we,
  output logic [7:0]            map_wr_addr,
  output logic [DATA_WIDTH-1:0] map_wr_data,
  output logic                  busy,
  output logic                  blast_done
);

  // Placement handshake: a request transfers on a cycle with place_valid & place_ready.
  // place_ready is high only in IDLE, so requests made while busy are dropped, not queued.

  localparam logic [DATA_WIDTH-1:0] T_EMPTY = DATA_WIDTH'(0);
  localparam logic [DATA_WIDTH-1:0] T_BOMB  = DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] T_BLAST = DATA_WIDTH'(4);
`ifdef DESTROY_BRICK_EN
  localparam logic [DATA_WIDTH-1:0] T_BRICK = DATA_WIDTH'(2);
`endif
  localparam logic [31:0] FUSE_LAST = 32'(FUSE_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_FUSE, S_CENTER, S_RD, S_EVAL, S_HOLD, S_CLEAR
  } state_t;

  state_t          state, state_next;
  logic [3:0]      row_q;
  logic [4:0]      col_q;
  logic [1:0]      dir_q;
  logic [2:0]      k_q;
  logic [31:0]     cnt_q;
  logic [3:0][2:0] reach_q;

  logic            place_ok;
  logic            tile_cont, tile_write;
  int              srch_dir, srch_k;
  logic            srch_clear;
  logic            hit;
  logic [1:0]      hit_dir;
  logic [2:0]      hit_k;

  // Tile k steps from the bomb along ray d (0 up, 1 down, 2 left, 3 right); k=0 is the bomb.
  function automatic void ray_pos(input int d, input int k, output int r, output int c);
    r = int'(row_q);
    c = int'(col_q);
    case (d)
      0:       r = r - k;
      1:       r = r + k;
      2:       c = c - k;
      default: c = c + k;
    endcase
  endfunction

  function automatic logic [7:0] ray_addr(input int d, input int k);
    int r, c;
    ray_pos(d, k, r, c);
    return 8'(r * NUM_COL + c);
  endfunction

  assign place_ok = (int'(place_row) < NUM_ROW) && (int'(place_col) < NUM_COL);

  always_comb begin
    tile_cont = (map_rd_data == T_EMPTY) || (map_rd_data == T_BOMB) || (map_rd_data == T_BLAST);
`ifdef DESTROY_BRICK_EN
    tile_write = tile_cont || (map_rd_data == T_BRICK);
`else
    tile_write = tile_cont;
`endif
  end

  // Where to resume the walk: same ray one step further, or the start of the next ray.
  always_comb begin
    srch_dir   = 0;
    srch_k     = 1;
    srch_clear = 1'b0;
    case (state)
      S_EVAL: begin
        if (tile_cont) begin
          srch_dir = int'(dir_q);
          srch_k   = int'(k_q) + 1;
        end else begin
          srch_dir = int'(dir_q) + 1;
          srch_k   = 1;
        end
      end
      S_CLEAR: begin
        srch_dir   = int'(dir_q);
        srch_k     = int'(k_q) + 1;
        srch_clear = 1'b1;
      end
      default: ;
    endcase
  end

  // First usable (dir, k) at or after the resume point. Skipping happens in the same
  // cycle, so rays blocked by a map edge or with nothing to clear cost no cycles.
  always_comb begin
    int r, c, kk;
    hit     = 1'b0;
    hit_dir = '0;
    hit_k   = '0;
    r       = 0;
    c       = 0;
    kk      = 0;
    for (int d = 0; d < 4; d++) begin
      if (!hit && d >= srch_dir) begin
        kk = (d == srch_dir) ? srch_k : 1;
        ray_pos(d, kk, r, c);
        if (srch_clear ? (kk <= int'(reach_q[d]))
                       : (kk <= BLAST_RANGE && r >= 0 && r < NUM_ROW && c >= 0 && c < NUM_COL)) begin
          hit     = 1'b1;
          hit_dir = 2'(d);
          hit_k   = 3'(kk);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    place_ready = 1'b0;
    place_err   = 1'b0;
    map_rd_addr = '0;
    map_we      = 1'b0;
    map_wr_addr = '0;
    map_wr_data = '0;
    blast_done  = 1'b0;
    case (state)
      S_IDLE: begin
        place_ready = 1'b1;
        if (place_valid) begin
          if (place_ok) state_next = S_ARM;
          else          place_err  = 1'b1;
        end
      end
      S_ARM: begin
        map_we      = 1'b1;
        map_wr_addr = ray_addr(0, 0);
        map_wr_data = T_BOMB;
        state_next  = S_FUSE;
      end
      S_FUSE: if (cnt_q == FUSE_LAST) state_next = S_CENTER;
      S_CENTER: begin
        map_we      = 1'b1;
        map_wr_addr = ray_addr(0, 0);
        map_wr_data = T_BLAST;
        state_next  = hit ? S_RD : S_HOLD;
      end
      S_RD: begin
        map_rd_addr = ray_addr(int'(dir_q), int'(k_q));
        state_next  = S_EVAL;
      end
      S_EVAL: begin
        if (tile_write) begin
          map_we      = 1'b1;
          map_wr_addr = ray_addr(int'(dir_q), int'(k_q));
          map_wr_data = T_BLAST;
        end
        state_next = hit ? S_RD : S_HOLD;
      end
      S_HOLD: if (cnt_q == HOLD_LAST) state_next = S_CLEAR;
      S_CLEAR: begin
        map_we      = 1'b1;
        map_wr_addr = ray_addr(int'(dir_q), int'(k_q));
        map_wr_data = T_EMPTY;
        if (!hit) begin
          blast_done = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = ~place_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q   <= '0;
      col_q   <= '0;
      dir_q   <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      reach_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (place_valid && place_ok) begin
            row_q <= place_row;
            col_q <= place_col;
          end
        end
        S_ARM: begin
          cnt_q   <= '0;
          reach_q <= '0;
        end
        S_FUSE: cnt_q <= (cnt_q == FUSE_LAST) ? '0 : cnt_q + 32'd1;
        S_CENTER: begin
          if (hit) begin
            dir_q <= hit_dir;
            k_q   <= hit_k;
          end
        end
        S_EVAL: begin
          if (tile_write) reach_q[dir_q] <= k_q;
          if (hit) begin
            dir_q <= hit_dir;
            k_q   <= hit_k;
          end
        end
        S_HOLD: begin
          // k=0 makes the first CLEAR write land on the bomb tile.
          if (cnt_q == HOLD_LAST) begin
            cnt_q <= '0;
            dir_q <= '0;
            k_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_CLEAR: begin
          if (hit) begin
            dir_q <= hit_dir;
            k_q   <= hit_k;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_map_blast_writer.sv
// tb_map_blast_writer: drives bomb placements into map_blast_writer over a modelled
// tile_map_mem and compares map writes and the final map against a ray-walking model.
module tb_map_blast_writer;

  localparam int NUM_ROW = 11;
  localparam int NUM_COL = 19;
  localparam int FUSE    = 6;
  localparam int HOLD    = 5;
  localparam int RANGE   = 2;
  localparam int NCELL   = NUM_ROW * NUM_COL;
`ifdef DESTROY_BRICK_EN
  localparam bit DESTROY = 1'b1;
`else
  localparam bit DESTROY = 1'b0;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic       place_valid;
  logic [3:0] place_row;
  logic [4:0] place_col;
  logic       place_ready, place_err, map_we, busy, blast_done;
  logic [7:0] map_rd_addr, map_wr_addr;
  logic [3:0] map_rd_data, map_wr_data;

  always #5 clk = ~clk;

  map_blast_writer #(
    .NUM_ROW(NUM_ROW), .NUM_COL(NUM_COL), .DATA_WIDTH(4),
    .FUSE_CYCLES(FUSE), .HOLD_CYCLES(HOLD), .BLAST_RANGE(RANGE)
  ) dut (
    .clk(clk), .rst(rst),
    .place_valid(place_valid), .place_row(place_row), .place_col(place_col),
    .place_ready(place_ready), .place_err(place_err),
    .map_rd_addr(map_rd_addr), .map_rd_data(map_rd_data),
    .map_we(map_we), .map_wr_addr(map_wr_addr), .map_wr_data(map_wr_data),
    .busy(busy), .blast_done(blast_done)
  );

  // tile_map_mem model: 1-cycle read latency, loadable from init_map
  logic [3:0] init_map [0:255];
  logic [3:0] exp_map  [0:255];
  logic [3:0] mem      [0:255];
  logic       load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_map[i];
    end else if (map_we) begin
      mem[map_wr_addr] <= map_wr_data;
    end
    map_rd_data <= mem[map_rd_addr];
  end

  // write / pulse monitor
  logic [11:0] wq[$];
  int          wt[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          rd_oob = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (map_we) begin
      wq.push_back({map_wr_addr, map_wr_data});
      wt.push_back(cyc);
    end
    if (blast_done) done_cnt++;
    if (int'(map_rd_addr) >= NCELL) rd_oob++;
  end

  // scoreboard
  logic [11:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk each ray from the spec rules, then list the clear writes.
  task automatic build_expect(input int r0, input int c0);
    int reach [4];
    int r, c, a, t, ba;
    ba = r0 * NUM_COL + c0;
    exp_q.delete();
    exp_q.push_back({8'(ba), 4'd3});
    exp_q.push_back({8'(ba), 4'd4});
    for (int d = 0; d < 4; d++) begin
      reach[d] = 0;
      for (int k = 1; k <= RANGE; k++) begin
        r = r0 + ((d == 0) ? -k : (d == 1) ? k : 0);
        c = c0 + ((d == 2) ? -k : (d == 3) ? k : 0);
        if (r < 0 || r >= NUM_ROW || c < 0 || c >= NUM_COL) break;
        a = r * NUM_COL + c;
        t = int'(init_map[a]);
        if (t == 0 || t == 3 || t == 4) begin
          exp_q.push_back({8'(a), 4'd4});
          reach[d] = k;
        end else if (t == 2 && DESTROY) begin
          exp_q.push_back({8'(a), 4'd4});
          reach[d] = k;
          break;
        end else begin
          break;
        end
      end
    end
    exp_q.push_back({8'(ba), 4'd0});
    for (int d = 0; d < 4; d++) begin
      for (int k = 1; k <= reach[d]; k++) begin
        r = r0 + ((d == 0) ? -k : (d == 1) ? k : 0);
        c = c0 + ((d == 2) ? -k : (d == 3) ? k : 0);
        exp_q.push_back({8'(r * NUM_COL + c), 4'd0});
      end
    end
    for (int i = 0; i < 256; i++) exp_map[i] = init_map[i];
    foreach (exp_q[i]) exp_map[exp_q[i][11:4]] = exp_q[i][3:0];
  endtask

  // driver tasks
  task automatic load_map();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic fill_map(input int kind);
    for (int i = 0; i < 256; i++) begin
      init_map[i] = 4'd0;
      if (i < NCELL && kind == 1 && ((i / NUM_COL) % 2 == 1) && ((i % NUM_COL) % 2 == 1))
        init_map[i] = 4'd1;
    end
  endtask

  task automatic run_bomb(input string tag, input int r0, input int c0, input bit poke_busy);
    int base, dbase, obase, n, bad;
    build_expect(r0, c0);
    base  = wq.size();
    dbase = done_cnt;
    obase = rd_oob;
    @(negedge clk);
    place_valid = 1'b1;
    place_row   = 4'(r0);
    place_col   = 5'(c0);
    #1;
    chk({tag, ".ready"}, 32'(place_ready), 32'd1);
    chk({tag, ".err"}, 32'(place_err), 32'd0);
    @(negedge clk);
    place_valid = 1'b0;
    if (poke_busy) begin
      repeat (2) @(negedge clk);
      place_valid = 1'b1;
      place_row   = 4'($urandom_range(0, NUM_ROW - 1));
      place_col   = 5'($urandom_range(0, NUM_COL - 1));
      #1;
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".busy_ready"}, 32'(place_ready), 32'd0);
      repeat (3) @(negedge clk);
      place_valid = 1'b0;
    end
    for (int i = 0; i < FUSE + HOLD + 100 && done_cnt == dbase; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    n = wq.size() - base;
    chk({tag, ".done_pulses"}, 32'(done_cnt - dbase), 32'd1);
    chk({tag, ".nwrites"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++)
      chk($sformatf("%s.w%0d", tag, i), 32'(wq[base + i]), 32'(exp_q[i]));
    if (n >= 2) chk({tag, ".fuse_gap"}, 32'((wt[base + 1] - wt[base]) >= FUSE), 32'd1);
    chk({tag, ".rd_oob"}, 32'(rd_oob - obase), 32'd0);
    bad = 0;
    for (int i = 0; i < NCELL; i++) if (mem[i] !== exp_map[i]) bad++;
    chk({tag, ".map_bad_cells"}, 32'(bad), 32'd0);
    chk({tag, ".ready_after"}, 32'(place_ready), 32'd1);
  endtask

  initial begin
    int base, dbase;
    rst         = 1'b1;
    place_valid = 1'b0;
    place_row   = '0;
    place_col   = '0;
    fill_map(0);
    repeat (3) @(negedge clk);
    chk("rst.ready", 32'(place_ready), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.we", 32'(map_we), 32'd0);
    chk("rst.err", 32'(place_err), 32'd0);
    chk("rst.done", 32'(blast_done), 32'd0);
    chk("rst.rd_addr", 32'(map_rd_addr), 32'd0);
    chk("rst.wr_addr", 32'(map_wr_addr), 32'd0);
    chk("rst.wr_data", 32'(map_wr_data), 32'd0);
    rst = 1'b0;
    load_map();

    // centre bomb on an empty map: all eight ray tiles reached
    run_bomb("empty_5_9", 5, 9, 1'b0);

    // corner bomb on the walled default map: up/left rays must not read
    fill_map(1);
    load_map();
    run_bomb("corner_0_0", 0, 0, 1'b0);
    run_bomb("corner_10_18", 10, 18, 1'b1);

    // hard wall to the right of the bomb
    fill_map(0);
    init_map[5 * NUM_COL + 10] = 4'd1;
    load_map();
    run_bomb("wall_right", 5, 9, 1'b0);

    // brick above the bomb
    fill_map(0);
    init_map[85] = 4'd2;
    load_map();
    run_bomb("brick_up", 5, 9, 1'b0);
    chk("brick.tile85", 32'(mem[85]), DESTROY ? 32'd0 : 32'd2);
    chk("brick.tile66", 32'(mem[66]), 32'd0);

    // out-of-range placements
    base = wq.size();
    @(negedge clk);
    place_valid = 1'b1; place_row = 4'd11; place_col = 5'd3;
    #1;
    chk("oor_row.err", 32'(place_err), 32'd1);
    chk("oor_row.we", 32'(map_we), 32'd0);
    @(negedge clk);
    place_row = 4'd0; place_col = 5'd19;
    #1;
    chk("oor_col.err", 32'(place_err), 32'd1);
    chk("oor_col.ready", 32'(place_ready), 32'd1);
    @(negedge clk);
    place_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("oor.ready_after", 32'(place_ready), 32'd1);
    chk("oor.err_after", 32'(place_err), 32'd0);
    chk("oor.no_writes", 32'(wq.size() - base), 32'd0);

    // reset during FUSE aborts without clean-up
    @(negedge clk);
    place_valid = 1'b1; place_row = 4'd3; place_col = 5'd3;
    @(negedge clk);
    place_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("fuse.busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.ready", 32'(place_ready), 32'd1);
    chk("midrst.we", 32'(map_we), 32'd0);
    rst   = 1'b0;
    base  = wq.size();
    dbase = done_cnt;
    repeat (FUSE + HOLD + 40) @(negedge clk);
    chk("midrst.no_writes", 32'(wq.size() - base), 32'd0);
    chk("midrst.no_done", 32'(done_cnt - dbase), 32'd0);

    // random maps and bomb positions
    for (int it = 0; it < 8; it++) begin
      int v;
      for (int i = 0; i < 256; i++) begin
        v = $urandom_range(0, 9);
        init_map[i] = (v <= 4) ? 4'd0 : (v == 5 || v == 6) ? 4'd1 : (v == 7) ? 4'd2 :
                      (v == 8) ? 4'd3 : 4'd4;
      end
      load_map();
      run_bomb($sformatf("rand%0d", it), $urandom_range(0, NUM_ROW - 1),
               $urandom_range(0, NUM_COL - 1), it[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
